fb_writer: RTL and testbench
============================

// Module: fb_writer
// PURPOSE
//  Sink for the rasterizer pixel stream: accepts {pixel, color} beats over valid/ready and writes them
//  into a linear framebuffer memory port. Sits between raster and the framebuffer RAM/scan-out.
//  Also performs a hardware clear of the whole framebuffer to a programmable color.
// PARAMETERS
//  FB_WIDTH   320                 visible pixels per row
//  FB_HEIGHT  240                 visible rows
//  ADDR_W     18                  memory word address width; must hold 2*FB_WIDTH*FB_HEIGHT-1
// PORTS
//  clk          in   1            single clock
//  rst          in   1            asynchronous, active-high reset
//  vld_in       in   1            pixel beat valid (driven by raster vld_out)
//  rdy_in       out  1            pixel beat accepted when vld_in&&rdy_in (to raster rdy_out)
//  pixel_in     in   coord_2d_t   screen position; integer x/y fields used
//  color_in     in   `NUM_COLORS  pixel color
//  clear_req    in   1            1-cycle pulse: start framebuffer clear
//  clear_color  in   `NUM_COLORS  sampled on clear_req
//  mem_we       out  1            write request valid
//  mem_rdy      in   1            memory accepts write when mem_we&&mem_rdy
//  mem_addr     out  ADDR_W       word address
//  mem_wdata    out  `NUM_COLORS  write data
//  busy         out  1            high in CLEAR or while a write is pending
//  drop_cnt     out  16           count of out-of-bounds pixels dropped, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset: state=RUN, mem_we=0, mem_addr=0, mem_wdata=0, drop_cnt=0, busy=0. rdy_in is 1 in RUN with no pending write.
//  Write slot: one output register; mem_we/addr/wdata held stable until mem_rdy. Slot frees on handshake.
//  RUN: rdy_in = !clear_pending && (!mem_we || mem_rdy). Accepted in-bounds beat loads the slot next cycle.
//   Latency: accept at cycle N -> mem_we=1 at N+1. Back-to-back 1 beat/cycle when mem_rdy stays 1.
//   addr = base + y*FB_WIDTH + x, computed in ADDR_W bits. base=0 without FB_DOUBLE_BUFFER_EN.
//   Out of bounds (x>=FB_WIDTH or y>=FB_HEIGHT, coords unsigned) -> beat accepted, no write, drop_cnt++.
//  clear_req in RUN: latch clear_color and set clear_pending (rdy_in drops next cycle). When the slot is
//   empty or frees, go to CLEAR with ptr=0.
//  CLEAR: rdy_in=0. Issue writes of clear_color to base+ptr, ptr=0..FB_WIDTH*FB_HEIGHT-1, advancing on
//   mem_rdy. After the last handshake, return to RUN the next cycle.
//  clear_req in CLEAR or while clear_pending -> ignored.
//  clear_req in the same cycle as an accepted beat -> the beat is written first, then the clear runs.
//  Async rst mid-clear or mid-write -> immediate reset values. The partial clear is abandoned.
//  drop_cnt is cleared only by rst.
// CONFIGURATION
//  FB_DOUBLE_BUFFER_EN defined: adds inputs swap_req (1-cycle pulse) and output front_sel (1b, reset 0).
//   Writes and clears target the back buffer: base = (!front_sel)*FB_WIDTH*FB_HEIGHT.
//   swap_req toggles front_sel only when the slot is empty and there is no CLEAR/clear_pending. Otherwise
//   it is held pending and applied at the first such cycle. rdy_in=0 while a swap is pending.
//  Not defined: single buffer, base=0, no swap_req/front_sel ports.
// STRUCTURE
//  raster_defines.svh / shared package: coord_2d_t, `NUM_COLORS, fb_state_t {RUN, CLEAR},
//   FB_PIXELS localparam helper.
//  One sub-module: fb_addr_gen (combinational y*FB_WIDTH+x+base and bounds check), reused by the clear path.
// TESTING
//  1 Reset, mem_rdy=1, beats (0,0,c=3),(319,239,c=5) back-to-back -> mem writes addr 0 d3, addr 76799 d5,
//    each 1 cycle after accept.
//  2 Beat (320,0) then (0,240) -> no mem_we, drop_cnt=2. The next valid beat is written normally.
//  3 mem_rdy=0 for 5 cycles with a write pending -> rdy_in=0, mem_addr/wdata stable. Release -> write
//    completes, rdy_in=1.
//  4 clear_req with clear_color=7, mem_rdy=1 -> 76800 writes of 7 to addr 0..76799, rdy_in=0 throughout,
//    then RUN. A second clear_req mid-clear is ignored.
//  5 Accepted beat (10,2) coincident with clear_req -> write addr 650 precedes clear addr 0.
//    rst mid-clear -> mem_we=0 immediately.
//  6 FB_DOUBLE_BUFFER_EN: beat (0,0) -> addr 76800. swap_req -> front_sel=1. Beat (0,0) -> addr 0.
//    swap_req during a pending write takes effect after that write.

Source files
------------

// File: rtl/fb_writer_pkg.sv
// Shared types for the framebuffer writer: coordinate beat, color width,
// writer state encoding and a framebuffer size helper.
package fb_writer_pkg;

   localparam int unsigned COORD_W = 16;   // unsigned integer screen coordinate
   localparam int unsigned COLOR_W = 8;    // pixel color width

   typedef struct packed {
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] x;
   } coord_2d_t;

   typedef enum logic {
      RUN   = 1'b0,
      CLEAR = 1'b1
   } fb_state_t;

   // Number of pixels in one framebuffer.
   function automatic int unsigned fb_pixels(input int unsigned width, input int unsigned height);
      return width * height;
   endfunction

endpackage

// File: rtl/fb_writer_addr_gen.sv
// fb_addr_gen: linear framebuffer address and bounds check.
//   x, y       in   pixel coordinate (unsigned)
//   base       in   word address of the target buffer
//   addr       out  base + y*FB_WIDTH + x, in ADDR_W bits
//   in_bounds  out  x < FB_WIDTH and y < FB_HEIGHT
module fb_addr_gen
   import fb_writer_pkg::*;
#(
   parameter int unsigned FB_WIDTH  = 320,
   parameter int unsigned FB_HEIGHT = 240,
   parameter int unsigned ADDR_W    = 18
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [ADDR_W-1:0]  base,
   output logic [ADDR_W-1:0]  addr,
   output logic               in_bounds
);

   assign in_bounds = (32'(x) < FB_WIDTH) && (32'(y) < FB_HEIGHT);
   assign addr      = base + ADDR_W'(y) * ADDR_W'(FB_WIDTH) + ADDR_W'(x);

endmodule

// File: rtl/fb_writer.sv
// fb_writer: sink for the rasterizer pixel stream. Accepts {pixel, color}
// beats over valid/ready and writes them through a single output slot into
// a linear framebuffer memory port; also clears the whole framebuffer to a
// programmable color.
//   clk, rst       clock, asynchronous active-high reset
//   vld_in/rdy_in  pixel beat handshake; pixel_in/color_in payload
//   clear_req      1-cycle pulse starting a clear to clear_color
//   mem_we/mem_rdy write handshake; mem_addr/mem_wdata held until accepted
//   busy           clear pending/running or a write outstanding
//   drop_cnt       saturating count of out-of-bounds beats
// Optional macro FB_DOUBLE_BUFFER_EN adds swap_req/front_sel; writes and
// clears then target the back buffer.
module fb_writer
   import fb_writer_pkg::*;
#(
   parameter int unsigned FB_WIDTH  = 320,
   parameter int unsigned FB_HEIGHT = 240,
   parameter int unsigned ADDR_W    = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vld_in,
   output logic               rdy_in,
   input  coord_2d_t          pixel_in,
   input  logic [COLOR_W-1:0] color_in,
   input  logic               clear_req,
   input  logic [COLOR_W-1:0] clear_color,
`ifdef FB_DOUBLE_BUFFER_EN
   input  logic               swap_req,
   output logic               front_sel,
`endif
   output logic               mem_we,
   input  logic               mem_rdy,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [COLOR_W-1:0] mem_wdata,
   output logic               busy,
   output logic [15:0]        drop_cnt
);

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(FB_WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FB_HEIGHT - 1);

   fb_state_t          state;
   logic               clear_pending;
   logic [COLOR_W-1:0] clr_color;
   logic [COORD_W-1:0] cx, cy;       // coordinate of the clear write in the slot
   logic [COORD_W-1:0] nx, ny;       // next clear coordinate in raster order
   logic               clr_last;
   logic               slot_free;
   logic               accept;
   logic               swap_hold;
   logic [ADDR_W-1:0]  base;
   logic [COORD_W-1:0] ag_x, ag_y;
   logic [ADDR_W-1:0]  ag_addr;
   logic               ag_in_bounds;

   // Slot can take a new write this cycle if empty or emptying.
   assign slot_free = !mem_we || mem_rdy;
   assign rdy_in    = (state == RUN) && !clear_pending && !swap_hold && slot_free;
   assign accept    = vld_in && rdy_in;
   assign busy      = (state == CLEAR) || mem_we || clear_pending;

   // Clear walks the buffer in raster order so the shared address generator serves both paths.
   assign clr_last = (cx == X_LAST) && (cy == Y_LAST);
   always_comb begin
      nx = cx + COORD_W'(1);
      ny = cy;
      if (cx == X_LAST) begin
         nx = '0;
         ny = cy + COORD_W'(1);
      end
   end

   // Address source: next clear pixel in CLEAR, first clear pixel while pending, else the beat.
   always_comb begin
      ag_x = pixel_in.x;
      ag_y = pixel_in.y;
      if (state == CLEAR) begin
         ag_x = nx;
         ag_y = ny;
      end else if (clear_pending) begin
         ag_x = '0;
         ag_y = '0;
      end
   end

   fb_addr_gen #(
      .FB_WIDTH  (FB_WIDTH),
      .FB_HEIGHT (FB_HEIGHT),
      .ADDR_W    (ADDR_W)
   ) u_addr_gen (
      .x         (ag_x),
      .y         (ag_y),
      .base      (base),
      .addr      (ag_addr),
      .in_bounds (ag_in_bounds)
   );

`ifdef FB_DOUBLE_BUFFER_EN
   localparam int unsigned PIXELS = fb_pixels(FB_WIDTH, FB_HEIGHT);

   logic swap_pending;
   logic can_swap;

   assign swap_hold = swap_pending;
   assign base      = front_sel ? '0 : ADDR_W'(PIXELS);
   // A beat accepted this cycle still belongs to the current back buffer.
   assign can_swap  = (state == RUN) && !clear_pending && !mem_we && !accept;

   // Front/back buffer selection with deferred swap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         front_sel    <= 1'b0;
         swap_pending <= 1'b0;
      end else if (swap_req || swap_pending) begin
         if (can_swap) begin
            front_sel    <= !front_sel;
            swap_pending <= 1'b0;
         end else begin
            swap_pending <= 1'b1;
         end
      end
   end
`else
   assign swap_hold = 1'b0;
   assign base      = '0;
`endif

   // Writer FSM, write slot and drop counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= RUN;
         clear_pending <= 1'b0;
         clr_color     <= '0;
         cx            <= '0;
         cy            <= '0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         drop_cnt      <= '0;
      end else begin
         if (mem_we && mem_rdy) mem_we <= 1'b0;
         case (state)
            RUN: begin
               if (accept) begin
                  if (ag_in_bounds) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= ag_addr;
                     mem_wdata <= color_in;
                  end else if (drop_cnt != 16'hFFFF) begin
                     drop_cnt <= drop_cnt + 16'd1;
                  end
               end
               if (clear_pending) begin
                  // Pending beat drains first; then the first clear write takes the slot.
                  if (slot_free) begin
                     state         <= CLEAR;
                     clear_pending <= 1'b0;
                     cx            <= '0;
                     cy            <= '0;
                     mem_we        <= 1'b1;
                     mem_addr      <= ag_addr;
                     mem_wdata     <= clr_color;
                  end
               end else if (clear_req) begin
                  clear_pending <= 1'b1;
                  clr_color     <= clear_color;
               end
            end
            CLEAR: begin
               // mem_we stays high for the whole clear; the default above drops it after the last.
               if (mem_rdy) begin
                  if (clr_last) begin
                     state <= RUN;
                  end else begin
                     cx       <= nx;
                     cy       <= ny;
                     mem_we   <= 1'b1;
                     mem_addr <= ag_addr;
                  end
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: directed scenarios plus randomized
// traffic, with a scoreboard of expected memory writes derived from pixel
// coordinates and clear requests.
module tb_fb_writer;
   import fb_writer_pkg::*;

   localparam int W    = 320;
   localparam int H    = 240;
   localparam int NPIX = W * H;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld_in, rdy_in;
   coord_2d_t   pixel_in;
   logic [7:0]  color_in, clear_color, mem_wdata;
   logic        clear_req, mem_we, mem_rdy, busy;
   logic [17:0] mem_addr;
   logic [15:0] drop_cnt;
`ifdef FB_DOUBLE_BUFFER_EN
   logic        swap_req, front_sel;
`endif

   fb_writer #(.FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_W(18)) dut (
      .clk         (clk),
      .rst         (rst),
      .vld_in      (vld_in),
      .rdy_in      (rdy_in),
      .pixel_in    (pixel_in),
      .color_in    (color_in),
      .clear_req   (clear_req),
      .clear_color (clear_color),
`ifdef FB_DOUBLE_BUFFER_EN
      .swap_req    (swap_req),
      .front_sel   (front_sel),
`endif
      .mem_we      (mem_we),
      .mem_rdy     (mem_rdy),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .busy        (busy),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: ordered list of expected writes. A clear is one entry
   // standing for NPIX writes of its color from its base upward.
   typedef struct {
      bit is_clear;
      int addr;
      int data;
   } exp_t;
   exp_t q[$];

`ifdef FB_DOUBLE_BUFFER_EN
   int exp_base = NPIX;
`else
   int exp_base = 0;
`endif
   int          drop_exp   = 0;
   bit          clr_active = 0;
   int          clr_ptr    = 0;
   int          clr_writes = 0;
   bit          prev_stall = 0;
   logic [17:0] prev_addr;
   logic [7:0]  prev_data;

   // Scoreboard monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         clr_active = 0;
         clr_ptr    = 0;
         drop_exp   = 0;
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            n_cmp++;
            if (mem_we !== 1'b1 || mem_addr !== prev_addr || mem_wdata !== prev_data) begin
               n_err++;
               $display("FAIL slot_hold: got we=%b addr=%0d data=%0d want we=1 addr=%0d data=%0d",
                        mem_we, mem_addr, mem_wdata, prev_addr, prev_data);
            end
         end
         prev_stall = (mem_we === 1'b1) && (mem_rdy === 1'b0);
         prev_addr  = mem_addr;
         prev_data  = mem_wdata;

         if (clr_active) begin
            n_cmp++;
            if (rdy_in !== 1'b0) begin
               n_err++;
               $display("FAIL rdy_during_clear: got %b want 0", rdy_in);
            end
         end

         if (mem_we === 1'b1 && mem_rdy === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_write: got addr=%0d data=%0d want no write", mem_addr, mem_wdata);
            end else if (q[0].is_clear) begin
               if (32'(mem_addr) !== 32'(q[0].addr + clr_ptr) || 32'(mem_wdata) !== 32'(q[0].data)) begin
                  n_err++;
                  $display("FAIL clear_write: got addr=%0d data=%0d want addr=%0d data=%0d",
                           mem_addr, mem_wdata, q[0].addr + clr_ptr, q[0].data);
               end
               clr_ptr++;
               clr_writes++;
               if (clr_ptr == NPIX) begin
                  void'(q.pop_front());
                  clr_ptr    = 0;
                  clr_active = 0;
               end
            end else begin
               if (32'(mem_addr) !== 32'(q[0].addr) || 32'(mem_wdata) !== 32'(q[0].data)) begin
                  n_err++;
                  $display("FAIL beat_write: got addr=%0d data=%0d want addr=%0d data=%0d",
                           mem_addr, mem_wdata, q[0].addr, q[0].data);
               end
               void'(q.pop_front());
            end
         end

         if (vld_in === 1'b1 && rdy_in === 1'b1) begin
            if (32'(pixel_in.x) < W && 32'(pixel_in.y) < H)
               q.push_back('{0, exp_base + int'(pixel_in.y) * W + int'(pixel_in.x), int'(color_in)});
            else if (drop_exp < 65535)
               drop_exp++;
         end

         if (clear_req === 1'b1 && !clr_active) begin
            clr_active = 1;
            q.push_back('{1, exp_base, int'(clear_color)});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until accepted; returns 1 cycle after the accepting edge.
   task automatic beat(input int x, input int y, input int c);
      bit acc = 0;
      int t = 0;
      vld_in     = 1'b1;
      pixel_in.x = 16'(x);
      pixel_in.y = 16'(y);
      color_in   = 8'(c);
      while (!acc && t < 200) begin
         @(negedge clk);
         acc = (rdy_in === 1'b1);
         tick();
         t++;
      end
      vld_in = 1'b0;
      n_cmp++;
      if (!acc) begin
         n_err++;
         $display("FAIL beat_accept_timeout: got no accept want accept within 200 cycles");
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (mem_we !== 1'b0 || mem_addr !== 18'd0 || mem_wdata !== 8'd0 || drop_cnt !== 16'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_values: got we=%b addr=%0d data=%0d drop=%0d busy=%b want all 0",
                  mem_we, mem_addr, mem_wdata, drop_cnt, busy);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (rdy_in !== 1'b1) begin
         n_err++;
         $display("FAIL reset_rdy: got %b want 1", rdy_in);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      mem_rdy = 1'b1;
      beat(0, 0, 3);
      n_cmp++;
      if (mem_we !== 1'b1 || 32'(mem_addr) !== 32'(exp_base) || mem_wdata !== 8'd3) begin
         n_err++;
         $display("FAIL b2b_first: got we=%b addr=%0d data=%0d want we=1 addr=%0d data=3",
                  mem_we, mem_addr, mem_wdata, exp_base);
      end
      beat(319, 239, 5);
      n_cmp++;
      if (mem_we !== 1'b1 || 32'(mem_addr) !== 32'(exp_base + 76799) || mem_wdata !== 8'd5) begin
         n_err++;
         $display("FAIL b2b_second: got we=%b addr=%0d data=%0d want we=1 addr=%0d data=5",
                  mem_we, mem_addr, mem_wdata, exp_base + 76799);
      end
      tick();
   endtask

   task automatic test_drop();
      mem_rdy = 1'b1;
      beat(320, 0, 1);
      n_cmp++;
      if (mem_we !== 1'b0) begin
         n_err++;
         $display("FAIL drop_x_no_write: got we=%b want 0", mem_we);
      end
      beat(0, 240, 1);
      n_cmp++;
      if (mem_we !== 1'b0 || drop_cnt !== 16'd2) begin
         n_err++;
         $display("FAIL drop_y: got we=%b drop=%0d want we=0 drop=2", mem_we, drop_cnt);
      end
      beat(5, 1, 9);
      n_cmp++;
      if (mem_we !== 1'b1 || 32'(mem_addr) !== 32'(exp_base + 325) || mem_wdata !== 8'd9) begin
         n_err++;
         $display("FAIL drop_then_valid: got we=%b addr=%0d data=%0d want we=1 addr=%0d data=9",
                  mem_we, mem_addr, mem_wdata, exp_base + 325);
      end
      tick();
   endtask

   task automatic test_stall();
      mem_rdy = 1'b0;
      beat(7, 3, 4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (rdy_in !== 1'b0 || mem_we !== 1'b1 || 32'(mem_addr) !== 32'(exp_base + 967) || mem_wdata !== 8'd4) begin
            n_err++;
            $display("FAIL stall_hold: got rdy=%b we=%b addr=%0d data=%0d want rdy=0 we=1 addr=%0d data=4",
                     rdy_in, mem_we, mem_addr, mem_wdata, exp_base + 967);
         end
         tick();
      end
      mem_rdy = 1'b1;
      tick();
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b0 || rdy_in !== 1'b1) begin
         n_err++;
         $display("FAIL stall_release: got we=%b rdy=%b want we=0 rdy=1", mem_we, rdy_in);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         vld_in     = ($urandom_range(99) < 70);
         pixel_in.x = 16'($urandom_range(340));
         pixel_in.y = 16'($urandom_range(255));
         color_in   = 8'($urandom);
         mem_rdy    = ($urandom_range(99) < 65);
         tick();
      end
      vld_in  = 1'b0;
      mem_rdy = 1'b1;
      repeat (4) tick();
      n_cmp++;
      if (q.size() != 0 || 32'(drop_cnt) !== 32'(drop_exp)) begin
         n_err++;
         $display("FAIL random_drain: got pending=%0d drop=%0d want pending=0 drop=%0d",
                  q.size(), drop_cnt, drop_exp);
      end
   endtask

   task automatic test_clear();
      int w0 = clr_writes;
      int t  = 0;
      mem_rdy     = 1'b1;
      clear_color = 8'd7;
      clear_req   = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (1000) tick();
      clear_color = 8'd9;
      clear_req   = 1'b1;
      tick();
      clear_req = 1'b0;
      while (busy === 1'b1 && t < 80000) begin
         tick();
         t++;
      end
      n_cmp++;
      if (busy !== 1'b0 || clr_writes - w0 != NPIX || q.size() != 0) begin
         n_err++;
         $display("FAIL clear_complete: got busy=%b writes=%0d pending=%0d want busy=0 writes=%0d pending=0",
                  busy, clr_writes - w0, q.size(), NPIX);
      end
      @(negedge clk);
      n_cmp++;
      if (rdy_in !== 1'b1) begin
         n_err++;
         $display("FAIL clear_back_to_run: got rdy=%b want 1", rdy_in);
      end
      tick();
   endtask

`ifdef FB_DOUBLE_BUFFER_EN
   task automatic test_swap();
      int t = 0;
      mem_rdy = 1'b1;
      beat(0, 0, 1);
      n_cmp++;
      if (mem_addr !== 18'd76800) begin
         n_err++;
         $display("FAIL swap_back_addr: got %0d want 76800", mem_addr);
      end
      tick();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      n_cmp++;
      if (front_sel !== 1'b1) begin
         n_err++;
         $display("FAIL swap_toggle: got %b want 1", front_sel);
      end
      exp_base = 0;
      beat(0, 0, 2);
      n_cmp++;
      if (mem_addr !== 18'd0) begin
         n_err++;
         $display("FAIL swap_front_addr: got %0d want 0", mem_addr);
      end
      tick();
      mem_rdy = 1'b0;
      beat(1, 0, 3);
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (front_sel !== 1'b1 || rdy_in !== 1'b0) begin
            n_err++;
            $display("FAIL swap_deferred: got front=%b rdy=%b want front=1 rdy=0", front_sel, rdy_in);
         end
         tick();
      end
      mem_rdy = 1'b1;
      while (front_sel === 1'b1 && t < 5) begin
         tick();
         t++;
      end
      n_cmp++;
      if (front_sel !== 1'b0 || q.size() != 0) begin
         n_err++;
         $display("FAIL swap_after_write: got front=%b pending=%0d want front=0 pending=0", front_sel, q.size());
      end
      exp_base = NPIX;
      beat(2, 0, 4);
      n_cmp++;
      if (mem_addr !== 18'd76802) begin
         n_err++;
         $display("FAIL swap_back_again: got %0d want 76802", mem_addr);
      end
      tick();
   endtask
`endif

   task automatic test_clear_coincident();
      mem_rdy     = 1'b1;
      vld_in      = 1'b1;
      pixel_in.x  = 16'd10;
      pixel_in.y  = 16'd2;
      color_in    = 8'd6;
      clear_color = 8'd2;
      clear_req   = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (rdy_in !== 1'b1) begin
         n_err++;
         $display("FAIL coincident_accept: got rdy=%b want 1", rdy_in);
      end
      tick();
      vld_in    = 1'b0;
      clear_req = 1'b0;
      n_cmp++;
      if (mem_we !== 1'b1 || 32'(mem_addr) !== 32'(exp_base + 650) || mem_wdata !== 8'd6) begin
         n_err++;
         $display("FAIL coincident_beat_first: got we=%b addr=%0d data=%0d want we=1 addr=%0d data=6",
                  mem_we, mem_addr, mem_wdata, exp_base + 650);
      end
      tick();
      n_cmp++;
      if (mem_we !== 1'b1 || 32'(mem_addr) !== 32'(exp_base) || mem_wdata !== 8'd2) begin
         n_err++;
         $display("FAIL coincident_clear_next: got we=%b addr=%0d data=%0d want we=1 addr=%0d data=2",
                  mem_we, mem_addr, mem_wdata, exp_base);
      end
      repeat (100) tick();
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (mem_we !== 1'b0 || busy !== 1'b0 || drop_cnt !== 16'd0 || mem_addr !== 18'd0) begin
         n_err++;
         $display("FAIL async_reset_mid_clear: got we=%b busy=%b drop=%0d addr=%0d want all 0",
                  mem_we, busy, drop_cnt, mem_addr);
      end
      repeat (2) tick();
      rst = 1'b0;
      tick();
      @(negedge clk);
      n_cmp++;
      if (rdy_in !== 1'b1 || mem_we !== 1'b0) begin
         n_err++;
         $display("FAIL after_abandoned_clear: got rdy=%b we=%b want rdy=1 we=0", rdy_in, mem_we);
      end
      tick();
   endtask

   initial begin
      rst         = 1'b1;
      vld_in      = 1'b0;
      pixel_in    = '0;
      color_in    = '0;
      clear_req   = 1'b0;
      clear_color = '0;
      mem_rdy     = 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
      swap_req    = 1'b0;
`endif
      test_reset();
      test_back_to_back();
      test_drop();
      test_stall();
      test_random();
      test_clear();
`ifdef FB_DOUBLE_BUFFER_EN
      test_swap();
`endif
      test_clear_coincident();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
